// File: rtl/record_serializer_if.sv
// Record-in / byte-out handshake bundle for record_serializer.
// recIn is big-endian: recIn[0:7] carries payload byte 0.
interface record_serializer_if #(
    parameter int unsigned NUM_BYTES = 37
) ();
    logic [0:8*NUM_BYTES-1] recIn;
    logic                   recIn_val;
    logic                   recIn_ready;
    logic                   recLost;
    logic [7:0]             byteOut;
    logic                   byteOut_val;
    logic                   byteOut_ready;
    logic                   byteOut_last;

    modport master (
        output recIn, recIn_val, recLost, byteOut_ready,
        input  recIn_ready, byteOut, byteOut_val, byteOut_last
    );

    modport slave (
        input  recIn, recIn_val, recLost, byteOut_ready,
        output recIn_ready, byteOut, byteOut_val, byteOut_last
    );
endinterface

// File: rtl/record_serializer.sv
// Serializes one parsed record per handshake into a flag byte plus payload bytes,
// with optional trailing-zero trimming and saturating status counters.
module record_serializer #(
    parameter int unsigned NUM_BYTES  = 37,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned TRIM_ZEROS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    record_serializer_if.slave   bus,
    output logic [CNT_W-1:0]     recCount,
    output logic [CNT_W-1:0]     lostCount,
    output logic [CNT_W-1:0]     badCount
);

    localparam int unsigned REC_W = 8 * NUM_BYTES;
    localparam int unsigned IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_BYTE = IDX_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t             state;
    logic [0:REC_W-1]   shadow;
    logic               bad_q;
    logic [IDX_W-1:0]   last_idx;
    logic [IDX_W-1:0]   idx;
    logic [7:0]         out_byte;
    logic               out_val;
    logic               out_last;
    logic               in_ready;

    logic               accept_c;
    logic               take_c;
    logic               in_bad_c;
    logic               in_lost_c;
    logic [IDX_W-1:0]   in_last_nz_c;
    logic [IDX_W-1:0]   in_last_idx_c;
    logic [IDX_W-1:0]   idx_inc_c;

    assign accept_c  = bus.recIn_val & in_ready;
    assign take_c    = out_val & bus.byteOut_ready;
    assign in_bad_c  = &bus.recIn;
    // A bad record never reports loss, neither in its flag byte nor in lostCount.
    assign in_lost_c = bus.recLost & ~in_bad_c;
    assign idx_inc_c = idx + IDX_W'(1);

    // Priority encoder: highest-indexed nonzero payload byte, 0 when all are zero.
    always_comb begin
        in_last_nz_c = '0;
        for (int unsigned i = 0; i < NUM_BYTES; i++) begin
            if (bus.recIn[8*i +: 8] != 8'h00) begin
                in_last_nz_c = IDX_W'(i);
            end
        end
    end

    assign in_last_idx_c = (TRIM_ZEROS != 0) ? in_last_nz_c : LAST_BYTE;

    function automatic logic [7:0] shadow_byte(input logic [IDX_W-1:0] i);
        return shadow[{i, 3'b000} +: 8];
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_byte  <= 8'h00;
            out_val   <= 1'b0;
            out_last  <= 1'b0;
            idx       <= '0;
            bad_q     <= 1'b0;
            last_idx  <= '0;
            recCount  <= '0;
            lostCount <= '0;
            badCount  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        shadow    <= bus.recIn;
                        bad_q     <= in_bad_c;
                        last_idx  <= in_last_idx_c;
                        recCount  <= sat_inc(recCount);
                        if (in_lost_c) lostCount <= sat_inc(lostCount);
                        if (in_bad_c)  badCount  <= sat_inc(badCount);
                        in_ready  <= 1'b0;
                        out_byte  <= {6'b000000, in_bad_c, in_lost_c};
                        out_val   <= 1'b1;
                        out_last  <= in_bad_c;
                        state     <= HDR;
                    end
                end
                HDR: begin
                    if (take_c) begin
                        if (bad_q) begin
                            out_val  <= 1'b0;
                            out_last <= 1'b0;
                            in_ready <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            idx      <= '0;
                            out_byte <= shadow_byte('0);
                            out_last <= (last_idx == '0);
                            state    <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (take_c) begin
                        if (out_last) begin
                            out_val  <= 1'b0;
                            out_last <= 1'b0;
                            in_ready <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            idx      <= idx_inc_c;
                            out_byte <= shadow_byte(idx_inc_c);
                            out_last <= (idx_inc_c == last_idx);
                        end
                    end
                end
                default: begin
                    out_val  <= 1'b0;
                    out_last <= 1'b0;
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.recIn_ready  = in_ready;
    assign bus.byteOut      = out_byte;
    assign bus.byteOut_val  = out_val;
    assign bus.byteOut_last = out_last;

endmodule
